// File: rtl/qam16_tx_sched.sv
// Frame scheduler sharing one QAM16 slicer between req0 (control) and req1 (data).
// Each frame: PRE_WORDS preamble words, a header word, the granted payload, then an idle gap.
module qam16_tx_sched #(
  parameter int unsigned PRE_WORDS  = 2,
  parameter logic [31:0] PREAMBLE   = 32'h5555_5555,
  parameter logic [15:0] HDR_TAG    = 16'hA5C3,
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic        req0_last,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic        req1_last,
  output logic        req1_ack,
  output logic        sl_valid,
  output logic [31:0] sl_data,
  input  logic        sl_ack,
  output logic        busy,
  output logic [1:0]  grant,
  output logic [7:0]  frame_seq,
  output logic        underrun
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, GAP} state_t;
  typedef struct packed { logic valid; logic last; logic [31:0] data; } req_t;

  localparam logic [3:0] PRE_LAST = 4'(PRE_WORDS - 1);
  localparam logic [7:0] PAY_LAST = 8'(MAX_WORDS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state, state_n;
  req_t [1:0]  req;
  req_t        cur;
  logic        src, rr, final_q, und_seen;
  logic [3:0]  pre_cnt;
  logic [7:0]  pay_cnt, gap_cnt;
  logic        any_req, win, acc, slot_free, pay_open, capture, und_hit;
  logic        sl_valid_n;
  logic [31:0] sl_data_n, hdr_word;

  assign req[0]   = {req0_valid, req0_last, req0_data};
  assign req[1]   = {req1_valid, req1_last, req1_data};
  assign cur      = req[src];
  assign any_req  = req0_valid | req1_valid;
  assign win      = (req0_valid & req1_valid) ? rr : req1_valid;
  assign acc      = sl_ack & sl_valid;
  assign slot_free = ~sl_valid | acc;
  // No capture while the ack pulse is out: the requester has not advanced its word yet
  assign pay_open = (state == PAY) & slot_free & ~(acc & final_q) & ~(req0_ack | req1_ack);
  assign capture  = pay_open & cur.valid;
  assign und_hit  = pay_open & ~cur.valid & ~und_seen;
  assign hdr_word = {HDR_TAG, frame_seq, 7'b0, src};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = PRE;
      PRE:     if (acc && pre_cnt == PRE_LAST) state_n = HDR;
      HDR:     if (acc) state_n = PAY;
      PAY:     if (acc && final_q) state_n = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sl_valid_n = sl_valid;
    sl_data_n  = sl_data;
    case (state)
      IDLE: if (any_req) begin
        sl_valid_n = 1'b1;
        sl_data_n  = PREAMBLE;
      end
      PRE:  if (acc && pre_cnt == PRE_LAST) sl_data_n = hdr_word;
      HDR:  if (acc) sl_valid_n = 1'b0;
      PAY: begin
        if (capture) begin
          sl_valid_n = 1'b1;
          sl_data_n  = cur.data;
        end else if (acc) begin
          sl_valid_n = 1'b0;
        end
      end
      default: sl_valid_n = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sl_valid  <= 1'b0;
      sl_data   <= '0;
      busy      <= 1'b0;
      grant     <= 2'b00;
      frame_seq <= '0;
      underrun  <= 1'b0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      src       <= 1'b0;
      rr        <= 1'b0;
      pre_cnt   <= '0;
      pay_cnt   <= '0;
      gap_cnt   <= '0;
      final_q   <= 1'b0;
      und_seen  <= 1'b0;
    end else begin
      sl_valid <= sl_valid_n;
      sl_data  <= sl_data_n;
      busy     <= (state_n != IDLE);
      req0_ack <= capture & ~src;
      req1_ack <= capture & src;
      underrun <= und_hit;
      if (capture)      und_seen <= 1'b0;
      else if (und_hit) und_seen <= 1'b1;
      case (state)
        IDLE: if (any_req) begin
          src      <= win;
          grant    <= win ? 2'b10 : 2'b01;
          pre_cnt  <= '0;
          pay_cnt  <= '0;
          final_q  <= 1'b0;
          und_seen <= 1'b0;
        end
        PRE: if (acc) pre_cnt <= pre_cnt + 4'd1;
        PAY: begin
          if (capture) begin
            pay_cnt <= pay_cnt + 8'd1;
            final_q <= cur.last | (pay_cnt == PAY_LAST);
          end
          if (acc && final_q) begin
            frame_seq <= frame_seq + 8'd1;
            gap_cnt   <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == GAP_LAST) begin
            rr    <= ~src;
            grant <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qam16_tx_sched.sv
// Bench for qam16_tx_sched: requester/slicer models plus a frame-level reference of the word stream.
module tb_qam16_tx_sched;
  localparam logic [31:0] PRE_W = 32'h5555_5555;
  localparam int GAP = 16;

  logic CLK = 0, RST = 1;
  logic req0_valid = 0, req0_last = 0, req1_valid = 0, req1_last = 0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ack, req1_ack, sl_valid, busy, underrun;
  logic [31:0] sl_data;
  logic sl_ack = 0;
  logic [1:0] grant;
  logic [7:0] frame_seq;

  qam16_tx_sched dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ack(req1_ack),
    .sl_valid(sl_valid), .sl_data(sl_data), .sl_ack(sl_ack),
    .busy(busy), .grant(grant), .frame_seq(frame_seq), .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] d; bit last; } word_t;
  word_t rq0[$], rq1[$], mq0[$], mq1[$];
  logic [31:0] sent[$], exp_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, wcnt = 0, ack_gap = 8, last_ack_cyc = 0, fall_cyc = 0;
  int ack0_cnt = 0, ack1_cnt = 0, und_cnt = 0;
  bit prev_busy = 0, stall1 = 0;
  int m_seq = 0;
  bit m_rr = 0;

  // Requesters pop on their ack pulse; the slicer acks after ack_gap cycles of valid
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      sl_ack = 0;
      wcnt = 0;
    end else begin
      if (req0_ack) begin ack0_cnt++; if (rq0.size() > 0) rq0.delete(0); end
      if (req1_ack) begin ack1_cnt++; if (rq1.size() > 0) rq1.delete(0); end
      if (underrun) und_cnt++;
      if (sl_ack) sl_ack = 0;
      else if (sl_valid) begin
        if (wcnt >= ack_gap - 1) begin
          sent.push_back(sl_data);
          sl_ack = 1;
          wcnt = 0;
          last_ack_cyc = cyc;
        end else wcnt++;
      end
      if (prev_busy && !busy) fall_cyc = cyc;
    end
    prev_busy = busy;
    if (rq0.size() > 0) begin req0_valid = 1; req0_data = rq0[0].d; req0_last = rq0[0].last; end
    else begin req0_valid = 0; req0_data = '0; req0_last = 0; end
    if (rq1.size() > 0 && !stall1) begin req1_valid = 1; req1_data = rq1[0].d; req1_last = rq1[0].last; end
    else begin req1_valid = 0; req1_data = '0; req1_last = 0; end
  end

  // Reference: whole frames, round-robin on ties, payload split at 64 words
  task automatic model_flush();
    word_t w;
    int s;
    while (mq0.size() > 0 || mq1.size() > 0) begin
      if (mq0.size() > 0 && mq1.size() > 0) s = m_rr;
      else s = (mq1.size() > 0) ? 1 : 0;
      for (int p = 0; p < 2; p++) exp_q.push_back(PRE_W);
      exp_q.push_back({16'hA5C3, 8'(m_seq), 7'b0, 1'(s)});
      for (int n = 0; n < 64; n++) begin
        if (s == 0) w = mq0.pop_front();
        else w = mq1.pop_front();
        exp_q.push_back(w.d);
        if (w.last) break;
      end
      m_seq = (m_seq + 1) % 256;
      m_rr = (s == 0);
    end
  endtask

  task automatic push_frame(input int ch, input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.d = $urandom;
      w.last = (i == n - 1);
      if (ch == 0) begin rq0.push_back(w); mq0.push_back(w); end
      else begin rq1.push_back(w); mq1.push_back(w); end
    end
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (rq0.size() == 0 && rq1.size() == 0 && !busy) begin to = 0; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1; sl_ack = 0;
    rq0.delete(); rq1.delete(); mq0.delete(); mq1.delete();
    repeat (2) @(negedge CLK);
    #1; RST = 0;
    m_seq = 0; m_rr = 0;
    sent.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (sl_valid !== 1'b0) begin errors++; $display("FAIL reset sl_valid: got %b want 0", sl_valid); end
    checks++; if (sl_data !== 32'h0) begin errors++; $display("FAIL reset sl_data: got %h want 0", sl_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset grant: got %b want 00", grant); end
    checks++; if (frame_seq !== 8'h00) begin errors++; $display("FAIL reset frame_seq: got %h want 0", frame_seq); end
    checks++; if ({req0_ack, req1_ack, underrun} !== 3'b000) begin errors++; $display("FAIL reset pulses: got %b want 000", {req0_ack, req1_ack, underrun}); end
    RST = 0;
  endtask

  task automatic test_single_frame();
    word_t w;
    bit to;
    int a0;
    logic [31:0] vals [3];
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222; vals[2] = 32'h3333_3333;
    sent.delete(); exp_q.delete(); ack_gap = 8; a0 = ack0_cnt;
    for (int i = 0; i < 3; i++) begin
      w.d = vals[i]; w.last = (i == 2);
      rq0.push_back(w); mq0.push_back(w);
    end
    model_flush();
    to = 1;
    for (int i = 0; i < 200; i++) begin @(negedge CLK); #1; if (busy) begin to = 0; break; end end
    checks++; if (to || grant !== 2'b01) begin errors++; $display("FAIL single grant: got %b want 01 (timeout=%0d)", grant, to); end
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL single done: timeout, busy=%b", busy); end
    checks++; if (sent.size() !== 6) begin errors++; $display("FAIL single count: got %0d want 6", sent.size()); end
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_q[i]) begin errors++; $display("FAIL single word %0d: got %h want %h", i, sent[i], exp_q[i]); end
    end
    checks++; if (ack0_cnt - a0 !== 3) begin errors++; $display("FAIL single acks: got %0d want 3", ack0_cnt - a0); end
    checks++; if (frame_seq !== 8'd1) begin errors++; $display("FAIL single frame_seq: got %0d want 1", frame_seq); end
    checks++; if (fall_cyc - last_ack_cyc !== GAP + 1) begin errors++; $display("FAIL single busy fall: got %0d want %0d", fall_cyc - last_ack_cyc, GAP + 1); end
  endtask

  task automatic test_rr_arbitration();
    bit to;
    do_reset();
    ack_gap = $urandom_range(1, 8);
    push_frame(0, 1); push_frame(0, 1); push_frame(1, 1);
    model_flush();
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL rr done: timeout"); end
    checks++; if (sent.size() !== exp_q.size()) begin errors++; $display("FAIL rr count: got %0d want %0d", sent.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_q[i]) begin errors++; $display("FAIL rr word %0d: got %h want %h", i, sent[i], exp_q[i]); end
    end
    checks++;
    if (sent.size() < 7 || sent[6][15:0] !== 16'h0101) begin
      errors++; $display("FAIL rr second header: got %h want seq 01 src 01", (sent.size() < 7) ? 32'hx : sent[6]);
    end
    checks++; if (frame_seq !== 8'd3) begin errors++; $display("FAIL rr frame_seq: got %0d want 3", frame_seq); end
  endtask

  task automatic test_underrun();
    bit to;
    int a1, u0, highs;
    sent.delete(); exp_q.delete(); ack_gap = 8;
    a1 = ack1_cnt; u0 = und_cnt;
    push_frame(1, 6);
    model_flush();
    to = 1;
    for (int i = 0; i < 1000; i++) begin @(negedge CLK); #1; if (ack1_cnt - a1 >= 2) begin to = 0; break; end end
    checks++; if (to) begin errors++; $display("FAIL underrun reach: timeout, acks=%0d", ack1_cnt - a1); end
    stall1 = 1; req1_valid = 0; highs = 0;
    for (int k = 0; k < 20; k++) begin @(negedge CLK); #1; if (k >= 10 && sl_valid) highs++; end
    stall1 = 0;
    checks++; if (highs !== 0) begin errors++; $display("FAIL underrun stall valid: got %0d high cycles want 0", highs); end
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL underrun done: timeout"); end
    checks++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL underrun pulses: got %0d want 1", und_cnt - u0); end
    checks++; if (ack1_cnt - a1 !== 6) begin errors++; $display("FAIL underrun acks: got %0d want 6", ack1_cnt - a1); end
    checks++; if (sent.size() !== exp_q.size()) begin errors++; $display("FAIL underrun count: got %0d want %0d", sent.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_q[i]) begin errors++; $display("FAIL underrun word %0d: got %h want %h", i, sent[i], exp_q[i]); end
    end
  endtask

  task automatic test_truncation();
    bit to;
    int a0;
    logic [7:0] seq0;
    sent.delete(); exp_q.delete(); ack_gap = $urandom_range(1, 4);
    a0 = ack0_cnt; seq0 = frame_seq;
    push_frame(0, 70);
    model_flush();
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL trunc done: timeout"); end
    checks++; if (sent.size() !== 76) begin errors++; $display("FAIL trunc count: got %0d want 76", sent.size()); end
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_q[i]) begin errors++; $display("FAIL trunc word %0d: got %h want %h", i, sent[i], exp_q[i]); end
    end
    checks++;
    if (sent.size() < 70 || sent[69] !== {16'hA5C3, seq0 + 8'd1, 8'h00}) begin
      errors++; $display("FAIL trunc second header: got %h want %h", (sent.size() < 70) ? 32'hx : sent[69], {16'hA5C3, seq0 + 8'd1, 8'h00});
    end
    checks++; if (ack0_cnt - a0 !== 70) begin errors++; $display("FAIL trunc acks: got %0d want 70", ack0_cnt - a0); end
    checks++; if (frame_seq !== seq0 + 8'd2) begin errors++; $display("FAIL trunc frame_seq: got %0d want %0d", frame_seq, seq0 + 8'd2); end
  endtask

  task automatic test_spurious_ack();
    bit to;
    logic [7:0] seq0;
    sent.delete(); exp_q.delete(); ack_gap = $urandom_range(1, 8);
    seq0 = frame_seq;
    push_frame(1, 1);
    model_flush();
    to = 1;
    for (int i = 0; i < 1000; i++) begin @(negedge CLK); #1; if (frame_seq !== seq0) begin to = 0; break; end end
    checks++; if (to) begin errors++; $display("FAIL spurious reach gap: timeout"); end
    repeat (3) @(negedge CLK);
    #1; sl_ack = 1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (frame_seq !== seq0 + 8'd1) begin errors++; $display("FAIL spurious frame_seq: got %0d want %0d", frame_seq, seq0 + 8'd1); end
    checks++; if (sl_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL spurious gap state: got valid=%b busy=%b want 0 1", sl_valid, busy); end
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL spurious done: timeout"); end
    checks++; if (fall_cyc - last_ack_cyc !== GAP + 1) begin errors++; $display("FAIL spurious busy fall: got %0d want %0d", fall_cyc - last_ack_cyc, GAP + 1); end
    checks++; if (sent.size() !== exp_q.size()) begin errors++; $display("FAIL spurious count: got %0d want %0d", sent.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_q[i]) begin errors++; $display("FAIL spurious word %0d: got %h want %h", i, sent[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    word_t w;
    bit to;
    int a0;
    sent.delete(); exp_q.delete(); ack_gap = 3;
    a0 = ack0_cnt;
    for (int i = 0; i < 10; i++) begin w.d = $urandom; w.last = (i == 9); rq0.push_back(w); end
    to = 1;
    for (int i = 0; i < 1000; i++) begin @(negedge CLK); #1; if (ack0_cnt - a0 >= 2) begin to = 0; break; end end
    checks++; if (to) begin errors++; $display("FAIL midrst reach pay: timeout"); end
    RST = 1; sl_ack = 0; rq0.delete(); req0_valid = 0;
    a0 = ack0_cnt;
    @(negedge CLK); #1;
    checks++;
    if ({sl_valid, busy, grant, frame_seq, underrun, req0_ack, req1_ack} !== 15'h0 || sl_data !== 32'h0) begin
      errors++; $display("FAIL midrst outputs: got valid=%b busy=%b grant=%b seq=%h data=%h want all 0", sl_valid, busy, grant, frame_seq, sl_data);
    end
    RST = 0; m_seq = 0; m_rr = 0; sent.delete(); exp_q.delete();
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (ack0_cnt !== a0 || busy !== 1'b0) begin errors++; $display("FAIL midrst resumed: got acks=%0d busy=%b want %0d 0", ack0_cnt - a0, busy, 0); end
    push_frame(0, 2);
    model_flush();
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL midrst done: timeout"); end
    checks++;
    if (sent.size() < 3 || sent[0] !== PRE_W || sent[2] !== 32'hA5C3_0000) begin
      errors++; $display("FAIL midrst restart: got %h/%h want %h/%h", (sent.size() < 3) ? 32'hx : sent[0], (sent.size() < 3) ? 32'hx : sent[2], PRE_W, 32'hA5C3_0000);
    end
    checks++; if (sent.size() !== exp_q.size()) begin errors++; $display("FAIL midrst count: got %0d want %0d", sent.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_q[i]) begin errors++; $display("FAIL midrst word %0d: got %h want %h", i, sent[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_rr_arbitration();
    test_underrun();
    test_truncation();
    test_spurious_ack();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qam16_tx_sched.md
Name: qam16_tx_sched

Overview:
- Frame-level scheduler and arbiter that shares one QAM16 nibble slicer between two 32-bit word requesters (req0 = control channel, req1 = data channel).
- Arbitrates round-robin per frame.
- Emits a framed word stream to the slicer: preamble words, one header word, the granted requester's payload words, then an idle gap.
- Sits between the packet sources and the slicer input in the TX path.

Parameters:
- PRE_WORDS, 2, number of preamble words per frame (1..15).
- PREAMBLE, 32'h5555_5555, preamble word value.
- HDR_TAG, 16'hA5C3, upper 16 bits of the header word.
- MAX_WORDS, 64, maximum payload words per frame (1..255).
- GAP_CYCLES, 16, idle cycles after the last payload acceptance (8..255).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 word available.
- req0_data  in  32  requester 0 word.
- req0_last  in  1  requester 0 word is the last of its frame.
- req0_ack  out  1  registered one-cycle pulse: req0 word captured.
- req1_valid, req1_data, req1_last, req1_ack  same as req0, for requester 1.
- sl_valid  out  1  word valid to slicer (slicer valid_i).
- sl_data  out  32  word to slicer (slicer data_i).
- sl_ack  in  1  slicer acceptance pulse (slicer ack_i); arrives the cycle after the slicer samples.
- busy  out  1  high in every state except IDLE.
- grant  out  2  one-hot current owner; 2'b00 when none.
- frame_seq  out  8  count of completed frames, wraps 255->0.
- underrun  out  1  one-cycle pulse: payload slot empty while the frame is open.

Behaviour:
- Reset (synchronous, RST high at the clock edge) sets:
  - all outputs to 0;
  - the RR pointer to favour req0;
  - the state to IDLE.
- Reset mid-frame aborts immediately:
  - no further req_ack is issued;
  - a partially sent frame is not resumed.
- States: IDLE, PRE, HDR, PAY, GAP.
- IDLE:
  - If any reqN_valid is high, grant the requester with priority; ties go to the requester not granted last.
  - Load the first PREAMBLE word into sl_data, set sl_valid, and go to PRE.
  - Grant is registered and takes effect the next cycle.
- Word slot rule:
  - sl_data/sl_valid are held stable until sl_ack is seen.
  - In the sl_ack cycle the next word is registered into sl_data (visible the following cycle).
  - If no next word exists, sl_valid is cleared.
  - A word counts as sent on sl_ack only.
  - sl_ack while sl_valid is low is ignored.
- PRE: count accepted preamble words; after PRE_WORDS acceptances, load the header word and go to HDR.
- Header word: {HDR_TAG, frame_seq, 7'b0, src}, where src = 0 for req0 and 1 for req1.
- HDR: on sl_ack go to PAY and request the first payload word.
- PAY capture:
  - When the slot is empty (after sl_ack, or on entry) and the granted reqN_valid is high, capture reqN_data into sl_data and set sl_valid.
  - Pulse reqN_ack the following cycle.
  - No second capture may occur in the cycle reqN_ack is high.
- PAY underrun:
  - If the slot is empty and reqN_valid is low, pulse underrun once per empty episode and keep sl_valid low.
  - The frame stays open; the slicer may drop to idle.
- PAY frame end:
  - The captured word has last=1, or it is payload word number MAX_WORDS (truncation).
  - After that word's sl_ack: sl_valid low, frame_seq increments, and the state goes to GAP.
  - Truncated remaining words are sent as the next frame of that requester.
- GAP:
  - Hold sl_valid low for GAP_CYCLES cycles, counted from the cycle after the final sl_ack.
  - Then update the RR pointer to favour the other requester, clear grant, and go to IDLE.
  - Arbitration is evaluated in IDLE only; requests arriving mid-frame wait.
- The payload counter is 8 bits and resets on each grant.
- busy is registered and mirrors state != IDLE.

Test Plan:
- req0 valid only, 3 words (0x11111111, 0x22222222, 0x33333333 with last on the third), slicer model acks every 8 cycles:
  - sl_data sequence is 0x55555555, 0x55555555, {16'hA5C3, 8'h00, 8'h00}, 0x11111111, 0x22222222, 0x33333333;
  - exactly 3 req0_ack pulses;
  - frame_seq becomes 1;
  - busy falls GAP_CYCLES+1 cycles after the last sl_ack.
- req0 and req1 valid simultaneously from reset, each with 1-word frames:
  - req0 frame is sent first;
  - req1 frame follows with header low byte 0x01;
  - a third req0 frame waits until req1 is done.
- req1 drops valid for 20 cycles mid-payload:
  - exactly one underrun pulse;
  - sl_valid low during the stall;
  - frame resumes with the next word; no duplicated or missing words.
- req0 continuous 70-word frame with MAX_WORDS=64:
  - the first frame carries 64 payload words;
  - after GAP a second frame with frame_seq+1 carries the remaining 6 words.
- RST pulsed high for one cycle during PAY:
  - next cycle all outputs are 0 and the state is IDLE;
  - a new frame starts with the preamble and frame_seq=0.
- Spurious sl_ack while sl_valid is low in GAP: no state change and no counter change.
